// File: rtl/interrupt_controller.sv
// Priority interrupt controller: edge-captured maskable requests with fixed
// lowest-index priority, an independent non-maskable path, and EOI-terminated service.
module interrupt_controller #(
   parameter int N_SRC = 8,
   parameter int VEC_W = 3
) (
   input  logic             Clk,
   input  logic             Reset,
   input  logic [N_SRC-1:0] irq,
   input  logic             nmi_src,
   input  logic             en_we,
   input  logic [N_SRC-1:0] en_wdata,
   input  logic             eoi,
   input  logic             isInterrupted,
   input  logic             INA,
   output logic             INT,
   output logic             NMI,
   output logic [VEC_W-1:0] vector,
   output logic             in_service,
   output logic [N_SRC-1:0] pending,
   output logic [N_SRC-1:0] enable
);

   typedef enum logic [1:0] {
      IDLE    = 2'd0,
      ASSERT  = 2'd1,
      SERVICE = 2'd2
   } state_t;

   state_t state, state_nxt;

   logic [N_SRC-1:0] irq_d;
   logic [N_SRC-1:0] irq_rise;
   logic [N_SRC-1:0] eligible;
   logic [N_SRC-1:0] grant_mask;
   logic [N_SRC-1:0] pending_nxt;
   logic [VEC_W-1:0] winner;
   logic             any_eligible;
   logic             int_ack;
   logic             nmi_d;
   logic             nmi_rise;
   logic             nmi_ack;
   logic             nmi_pend;

   function automatic logic [VEC_W-1:0] lowest_index(input logic [N_SRC-1:0] req);
      logic [VEC_W-1:0] idx;
      idx = '0;
      for (int i = N_SRC - 1; i >= 0; i--) begin
         if (req[i]) idx = VEC_W'(i);
      end
      return idx;
   endfunction

   assign irq_rise     = irq & ~irq_d;
   assign nmi_rise     = nmi_src & ~nmi_d;
   assign eligible     = pending & enable;
   assign any_eligible = |eligible;
   assign winner       = lowest_index(eligible);
   assign grant_mask   = {{(N_SRC-1){1'b0}}, 1'b1} << winner;
   assign nmi_ack      = isInterrupted & ~INA;

   // A fresh edge on the acknowledged bit wins over the ack's clear.
   assign pending_nxt  = (pending & ~(int_ack ? grant_mask : '0)) | irq_rise;

   always_comb begin
      state_nxt = state;
      int_ack   = 1'b0;
      case (state)
         IDLE: begin
            if (any_eligible) state_nxt = ASSERT;
         end
         ASSERT: begin
            if (!any_eligible) begin
               state_nxt = IDLE;
            end else if (isInterrupted && INA) begin
               int_ack   = 1'b1;
               state_nxt = SERVICE;
            end
         end
         SERVICE: begin
            if (eoi) state_nxt = IDLE;
         end
         default: state_nxt = IDLE;
      endcase
   end

   always_ff @(posedge Clk or posedge Reset) begin
      if (Reset) begin
         state      <= IDLE;
         irq_d      <= '0;
         nmi_d      <= 1'b0;
         pending    <= '0;
         enable     <= '0;
         vector     <= '0;
         in_service <= 1'b0;
         nmi_pend   <= 1'b0;
      end else begin
         state   <= state_nxt;
         irq_d   <= irq;
         nmi_d   <= nmi_src;
         pending <= pending_nxt;
         if (en_we) enable <= en_wdata;
         if (int_ack) begin
            vector     <= winner;
            in_service <= 1'b1;
         end else if (state == SERVICE && eoi) begin
            in_service <= 1'b0;
         end
         // Simultaneous new NMI edge and NMI ack leaves the request pending.
         nmi_pend <= (nmi_pend & ~nmi_ack) | nmi_rise;
      end
   end

   assign INT = (state == ASSERT);
   assign NMI = nmi_pend;

endmodule
